demux32_1to4_dispatch: RTL



---
 rtl/demux_pkg.sv | 15 +
 rtl/demux_slot.sv | 42 ++++
 rtl/demux32_1to4_dispatch.sv | 65 ++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 word dispatcher.
// Channel count, select width, channel index type and pointer step.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] ch_idx_t;

  // Round-robin step; wraps 3 -> 0 through the 2-bit width.
  function automatic ch_idx_t next_ch(input ch_idx_t c);
    return c + ch_idx_t'(1);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: valid flag, held data word, handshake counter.
// Ports: clk, reset_n, load/load_data in, sink_ready in, valid/data/cnt out.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             sink_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt
);

  logic drain;

  assign drain = valid && sink_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
      cnt   <= '0;
    end else begin
      // A load wins over a drain so the slot stays full
      if (load) begin
        valid <= 1'b1;
        data  <= load_data;
      end else if (drain) begin
        valid <= 1'b0;
      end
      if (drain) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux32_1to4_dispatch.sv
// Registered 1-to-4 demux: select or round-robin routing into 4 slots.
// Ports: in_* valid/ready input, out_* per-channel flat outputs, rr_ptr.
module demux32_1to4_dispatch
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    rr_mode,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH*CNT_W-1:0] xfer_cnt,
  output logic [SEL_W-1:0]        rr_ptr
);

  ch_idx_t ptr_q;
  ch_idx_t tgt;
  logic    accept;

  always_comb begin
    tgt = rr_mode ? ptr_q : ch_idx_t'(in_sel);
  end

  // Never depends on in_valid; a busy target stalls, no skipping
  assign in_ready = reset_n &&
                    (!out_valid[tgt] || out_ready[tgt]);
  assign accept   = in_valid && in_ready;
  assign rr_ptr   = ptr_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (accept && rr_mode) begin
      ptr_q <= next_ch(ptr_q);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    logic load;

    assign load = accept && (tgt == ch_idx_t'(k));

    demux_slot #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
    ) u_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (load),
      .load_data (in_data),
      .sink_ready(out_ready[k]),
      .valid     (out_valid[k]),
      .data      (out_data[k*WIDTH +: WIDTH]),
      .cnt       (xfer_cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule
